pa_lsu_icc_vb: RTL and testbench

Victim buffer serving the LSU cache-maintenance (ICC) engine. It accepts dirty-line evictions from the ICC write-back path: an address handshake, then four 64-bit data beats. It holds each line until it has been written to the bus interface unit as a 4-beat burst, and reports empty so the ICC can complete its clean/flush sequence. It sits between the ICC FSM and the BIU write channel.

---
 rtl/pa_lsu_icc_vb.sv | 219 +++++++++++++++++++++
 tb/tb_pa_lsu_icc_vb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_lsu_icc_vb.sv
// pa_lsu_icc_vb -- victim buffer between the LSU ICC engine and the BIU write channel.
//
// Accepts dirty-line evictions from the ICC (address handshake, then four 64-bit
// beats). Each dirty line is held until it has been written to the BIU as a
// 4-beat burst. Clean lines are dropped once all four beats have arrived.
// vb_icc_empty tells the ICC that nothing is buffered or in flight.
//
// Configuration macro: PA_LSU_VB_TWO_ENTRY_EN
//   defined   : two entries; a second line can fill while the first is written,
//               and bursts follow allocation order (1-bit oldest pointer).
//   undefined : one entry; grants also wait for the write engine to be idle.
//
// Ports:
//   forever_cpuclk, cpurst        clock, synchronous active-high reset
//   icc_vb_create_en/addr/line_dirty, vb_icc_grant     entry allocation handshake
//   icc_vb_data_create/data_cnt/data                   line data beats
//   icc_vb_clr_vld                ICC draining; blocks new grants
//   vb_icc_empty                  all entries free and write engine idle
//   vb_biu_req/addr, biu_vb_grant                      burst request
//   vb_biu_data_vld/data/data_last, biu_vb_data_rdy    write beats
//   biu_vb_resp_vld               burst write complete
module pa_lsu_icc_vb (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        icc_vb_create_en,
    input  logic [26:0] icc_vb_addr,
    input  logic        icc_vb_line_dirty,
    input  logic        icc_vb_data_create,
    input  logic [1:0]  icc_vb_data_cnt,
    input  logic [63:0] icc_vb_data,
    input  logic        icc_vb_clr_vld,
    output logic        vb_icc_grant,
    output logic        vb_icc_empty,
    output logic        vb_biu_req,
    output logic [31:0] vb_biu_addr,
    input  logic        biu_vb_grant,
    output logic        vb_biu_data_vld,
    output logic [63:0] vb_biu_data,
    output logic        vb_biu_data_last,
    input  logic        biu_vb_data_rdy,
    input  logic        biu_vb_resp_vld
);

`ifdef PA_LSU_VB_TWO_ENTRY_EN
    localparam int unsigned NE = 2;
`else
    localparam int unsigned NE = 1;
`endif

    typedef enum logic [1:0] {E_FREE, E_FILL, E_READY, E_WRITE} ent_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA, W_RESP} wr_state_e;

    ent_state_e  ent_q  [NE];
    ent_state_e  ent_d  [NE];
    logic [26:0] addr_q [NE];
    logic        dirty_q[NE];
    logic [63:0] data_q [NE][4];
    logic [3:0]  mask_q [NE];

    wr_state_e   w_q;
    logic        sel_q;
    logic [1:0]  beat_q;
    logic        req_q, vld_q, last_q;
    logic [31:0] baddr_q;
    logic [63:0] bdata_q;

    logic        free_any, fill_any, pick_any, all_free;
    logic        gnt_idx, fill_idx, pick_idx;
    logic        grant_ok, fill_do, fill_done, w_pick, w_done;
    logic [3:0]  mask_nxt;

`ifdef PA_LSU_VB_TWO_ENTRY_EN
    logic        oldest_q, oldest_d;
    logic        rel0, rel1;
`endif

    // Entry status decode: all from registered state.
    always_comb begin
        free_any = 1'b0;
        fill_any = 1'b0;
        all_free = 1'b1;
        gnt_idx  = 1'b0;
        fill_idx = 1'b0;
        for (int unsigned i = NE; i > 0; i--) begin
            if (ent_q[i-1] == E_FREE) begin
                free_any = 1'b1;
                gnt_idx  = 1'(i-1);
            end else begin
                all_free = 1'b0;
            end
            if (ent_q[i-1] == E_FILL) begin
                fill_any = 1'b1;
                fill_idx = 1'(i-1);
            end
        end
`ifdef PA_LSU_VB_TWO_ENTRY_EN
        pick_any = (ent_q[0] == E_READY) || (ent_q[1] == E_READY);
        pick_idx = (ent_q[oldest_q] == E_READY) ? oldest_q : ~oldest_q;
        grant_ok = 1'b1;
`else
        pick_any = (ent_q[0] == E_READY);
        pick_idx = 1'b0;
        grant_ok = (w_q == W_IDLE);
`endif
    end

    assign vb_icc_grant = icc_vb_create_en & ~icc_vb_clr_vld & free_any & ~fill_any & grant_ok;
    assign vb_icc_empty = all_free & (w_q == W_IDLE);

    assign mask_nxt  = mask_q[fill_idx] | (4'b0001 << icc_vb_data_cnt);
    assign fill_do   = fill_any & icc_vb_data_create;
    assign fill_done = fill_do & (mask_nxt == 4'hF);
    assign w_pick    = (w_q == W_IDLE) & pick_any;
    assign w_done    = (w_q == W_RESP) & biu_vb_resp_vld;

    // Each event targets an entry in a distinct state, so they never collide.
    always_comb begin
        for (int unsigned i = 0; i < NE; i++) ent_d[i] = ent_q[i];
        if (vb_icc_grant) ent_d[gnt_idx]  = E_FILL;
        if (fill_done)    ent_d[fill_idx] = dirty_q[fill_idx] ? E_READY : E_FREE;
        if (w_pick)       ent_d[pick_idx] = E_WRITE;
        if (w_done)       ent_d[sel_q]    = E_FREE;
    end

`ifdef PA_LSU_VB_TWO_ENTRY_EN
    // Oldest points at the earlier-allocated busy entry; it moves to the
    // survivor when an entry is released, or to a fresh grant when alone.
    always_comb begin
        oldest_d = oldest_q;
        rel0 = (ent_q[0] != E_FREE) && (ent_d[0] == E_FREE);
        rel1 = (ent_q[1] != E_FREE) && (ent_d[1] == E_FREE);
        if (rel0 && ent_d[1] != E_FREE) oldest_d = 1'b1;
        if (rel1 && ent_d[0] != E_FREE) oldest_d = 1'b0;
        if (vb_icc_grant && ent_q[~gnt_idx] == E_FREE) oldest_d = gnt_idx;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) oldest_q <= 1'b0;
        else        oldest_q <= oldest_d;
    end
`endif

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int unsigned i = 0; i < NE; i++) begin
                ent_q[i]   <= E_FREE;
                addr_q[i]  <= '0;
                dirty_q[i] <= 1'b0;
                mask_q[i]  <= '0;
                for (int unsigned b = 0; b < 4; b++) data_q[i][b] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NE; i++) ent_q[i] <= ent_d[i];
            if (vb_icc_grant) begin
                addr_q[gnt_idx]  <= icc_vb_addr;
                dirty_q[gnt_idx] <= icc_vb_line_dirty;
                mask_q[gnt_idx]  <= '0;
            end
            if (fill_do) begin
                data_q[fill_idx][icc_vb_data_cnt] <= icc_vb_data;
                mask_q[fill_idx] <= mask_nxt;
            end
        end
    end

    // Write engine; bus outputs are loaded on state entry so they hold while stalled.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            w_q     <= W_IDLE;
            sel_q   <= 1'b0;
            beat_q  <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
        end else begin
            unique case (w_q)
                W_IDLE: if (pick_any) begin
                    w_q     <= W_REQ;
                    sel_q   <= pick_idx;
                    req_q   <= 1'b1;
                    baddr_q <= {addr_q[pick_idx], 5'b0};
                end
                W_REQ: if (biu_vb_grant) begin
                    w_q     <= W_DATA;
                    req_q   <= 1'b0;
                    baddr_q <= '0;
                    beat_q  <= '0;
                    vld_q   <= 1'b1;
                    last_q  <= 1'b0;
                    bdata_q <= data_q[sel_q][2'd0];
                end
                W_DATA: if (biu_vb_data_rdy) begin
                    if (beat_q == 2'd3) begin
                        w_q     <= W_RESP;
                        vld_q   <= 1'b0;
                        last_q  <= 1'b0;
                        bdata_q <= '0;
                        beat_q  <= '0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        bdata_q <= data_q[sel_q][beat_q + 2'd1];
                        last_q  <= (beat_q == 2'd2);
                    end
                end
                W_RESP: if (biu_vb_resp_vld) w_q <= W_IDLE;
                default: w_q <= W_IDLE;
            endcase
        end
    end

    assign vb_biu_req       = req_q;
    assign vb_biu_addr      = baddr_q;
    assign vb_biu_data_vld  = vld_q;
    assign vb_biu_data      = bdata_q;
    assign vb_biu_data_last = last_q;

endmodule

// File: tb/tb_pa_lsu_icc_vb.sv
module tb_pa_lsu_icc_vb;

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        icc_vb_create_en = 1'b0;
    logic [26:0] icc_vb_addr = '0;
    logic        icc_vb_line_dirty = 1'b0;
    logic        icc_vb_data_create = 1'b0;
    logic [1:0]  icc_vb_data_cnt = '0;
    logic [63:0] icc_vb_data = '0;
    logic        icc_vb_clr_vld = 1'b0;
    logic        vb_icc_grant, vb_icc_empty;
    logic        vb_biu_req;
    logic [31:0] vb_biu_addr;
    logic        biu_vb_grant = 1'b0;
    logic        vb_biu_data_vld;
    logic [63:0] vb_biu_data;
    logic        vb_biu_data_last;
    logic        biu_vb_data_rdy = 1'b0;
    logic        biu_vb_resp_vld = 1'b0;

    always #5 clk = ~clk;

    pa_lsu_icc_vb dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .icc_vb_create_en   (icc_vb_create_en),
        .icc_vb_addr        (icc_vb_addr),
        .icc_vb_line_dirty  (icc_vb_line_dirty),
        .icc_vb_data_create (icc_vb_data_create),
        .icc_vb_data_cnt    (icc_vb_data_cnt),
        .icc_vb_data        (icc_vb_data),
        .icc_vb_clr_vld     (icc_vb_clr_vld),
        .vb_icc_grant       (vb_icc_grant),
        .vb_icc_empty       (vb_icc_empty),
        .vb_biu_req         (vb_biu_req),
        .vb_biu_addr        (vb_biu_addr),
        .biu_vb_grant       (biu_vb_grant),
        .vb_biu_data_vld    (vb_biu_data_vld),
        .vb_biu_data        (vb_biu_data),
        .vb_biu_data_last   (vb_biu_data_last),
        .biu_vb_data_rdy    (biu_vb_data_rdy),
        .biu_vb_resp_vld    (biu_vb_resp_vld)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int last_resp_cyc = -10;
    int beat_cnt = 0;

    // BIU behaviour knobs
    int gnt_hold = 0;
    int stall_beat = -1;
    int stall_len = 0;

    logic [31:0] exp_addr_q[$];
    logic [64:0] exp_beat_q[$];

    function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc++;

    // BIU responder: drives at posedge+2, after the stimulus process.
    initial begin
        int gw = 0, bi = 0, sc = 0;
        logic rp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            biu_vb_grant = 1'b0;
            biu_vb_data_rdy = 1'b0;
            biu_vb_resp_vld = 1'b0;
            if (cpurst) begin
                gw = 0; bi = 0; sc = 0; rp = 1'b0;
            end else begin
                if (rp) begin
                    biu_vb_resp_vld = 1'b1;
                    rp = 1'b0;
                end
                if (vb_biu_req) begin
                    if (gw >= gnt_hold) begin
                        biu_vb_grant = 1'b1;
                        gw = 0;
                    end else gw++;
                end
                if (vb_biu_data_vld) begin
                    if (bi == stall_beat && sc < stall_len) sc++;
                    else begin
                        biu_vb_data_rdy = 1'b1;
                        if (vb_biu_data_last) begin
                            rp = 1'b1; bi = 0; sc = 0;
                        end else bi++;
                    end
                end
            end
        end
    end

    // Monitor: pops expected bus traffic whenever a handshake completes.
    logic        p_req = 1'b0, p_gnt = 1'b0, p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
    logic [31:0] p_addr = '0;
    logic [63:0] p_data = '0;

    always @(negedge clk) begin
        if (!cpurst) begin
            if (p_req && !p_gnt && vb_biu_req)
                check("addr_stable", 65'(vb_biu_addr), 65'(p_addr));
            if (p_vld && !p_rdy && vb_biu_data_vld)
                check("data_stable", {vb_biu_data_last, vb_biu_data}, {p_last, p_data});
            if (vb_biu_req && biu_vb_grant) begin
                if (exp_addr_q.size() == 0) check("unexpected_req", 65'(vb_biu_addr), 65'h1_0000_0000_0000_0000);
                else check("biu_addr", 65'(vb_biu_addr), 65'(exp_addr_q.pop_front()));
            end
            if (vb_biu_data_vld && biu_vb_data_rdy) begin
                beat_cnt++;
                if (exp_beat_q.size() == 0) check("unexpected_beat", {vb_biu_data_last, vb_biu_data}, 65'h0);
                else check("biu_beat", {vb_biu_data_last, vb_biu_data}, exp_beat_q.pop_front());
            end
            if (biu_vb_resp_vld) begin
                resp_cnt++;
                last_resp_cyc = cyc;
            end
        end
        p_req = vb_biu_req;   p_gnt = biu_vb_grant; p_addr = vb_biu_addr;
        p_vld = vb_biu_data_vld; p_rdy = biu_vb_data_rdy;
        p_data = vb_biu_data; p_last = vb_biu_data_last;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Returns grant cycle and resp bookkeeping seen at grant.
    task automatic create_line(input logic [26:0] a, input logic d, input logic [63:0] base,
                               output int gcyc, output int grc, output int glr);
        int n = 0;
        icc_vb_create_en = 1'b1;
        icc_vb_addr = a;
        icc_vb_line_dirty = d;
        #1;
        while (!vb_icc_grant && n < 100) begin
            cycle();
            #1;
            n++;
        end
        if (n >= 100) check("grant_timeout", 65'(vb_icc_grant), 65'h1);
        gcyc = cyc;
        grc = resp_cnt;
        glr = last_resp_cyc;
        if (d) exp_addr_q.push_back({a, 5'b0});
        cycle();
        icc_vb_create_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            icc_vb_data_create = 1'b1;
            icc_vb_data_cnt = 2'(b);
            icc_vb_data = base + 64'(b);
            if (d) exp_beat_q.push_back({(b == 3), base + 64'(b)});
            cycle();
        end
        icc_vb_data_create = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(vb_icc_empty && exp_addr_q.size() == 0 && exp_beat_q.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_empty"}, 65'(vb_icc_empty), 65'h1);
        check({name, "_beats_left"}, 65'(exp_beat_q.size()), 65'h0);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g, grc, glr, c0, rc, bc, n;

        // Reset values
        repeat (3) cycle();
        check("rst_grant", 65'(vb_icc_grant), 65'h0);
        check("rst_empty", 65'(vb_icc_empty), 65'h1);
        check("rst_req", 65'(vb_biu_req), 65'h0);
        check("rst_vld", 65'(vb_biu_data_vld), 65'h0);
        check("rst_last", 65'(vb_biu_data_last), 65'h0);
        check("rst_addr", 65'(vb_biu_addr), 65'h0);
        check("rst_data", 65'(vb_biu_data), 65'h0);
        cpurst = 1'b0;
        cycle();

        // Single dirty line
        c0 = cyc;
        create_line(27'h12345, 1'b1, 64'hA0, g, grc, glr);
        check("t1_grant_cycle", 65'(g), 65'(c0));
        n = 0;
        @(negedge clk);
        while (!biu_vb_resp_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_empty_at_resp", 65'(vb_icc_empty), 65'h0);
        @(negedge clk);
        check("t1_empty_after_resp", 65'(vb_icc_empty), 65'h1);
        check("t1_addr_left", 65'(exp_addr_q.size()), 65'h0);
        cycle();

        // Clean line: never reaches the bus
        create_line(27'h0ABCDE, 1'b0, 64'hC0, g, grc, glr);
        @(negedge clk);
        check("t2_empty", 65'(vb_icc_empty), 65'h1);
        repeat (3) @(negedge clk);
        check("t2_no_req", 65'(vb_biu_req), 65'h0);
        cycle();

        // Backpressure on grant and on beat 2
        gnt_hold = 3; stall_beat = 2; stall_len = 2;
        bc = beat_cnt;
        create_line(27'h7ABCDEF, 1'b1, 64'hDEAD_BEEF_0000_0010, g, grc, glr);
        wait_idle("t3");
        check("t3_beat_count", 65'(beat_cnt - bc), 65'h4);
        gnt_hold = 0; stall_beat = -1; stall_len = 0;

        // Two lines back-to-back
        rc = resp_cnt;
        create_line(27'h0000111, 1'b1, 64'h1000, g, grc, glr);
        create_line(27'h0000222, 1'b1, 64'h2000, g, grc, glr);
`ifdef PA_LSU_VB_TWO_ENTRY_EN
        check("t4_grant_during_write", 65'(grc), 65'(rc));
`else
        check("t4_grant_after_resp", 65'(g), 65'(glr + 1));
        check("t4_first_resp_seen", 65'(grc), 65'(rc + 1));
`endif
        wait_idle("t4");

        // clr_vld blocks grants
        icc_vb_clr_vld = 1'b1;
        icc_vb_create_en = 1'b1;
        icc_vb_addr = 27'h0000333;
        icc_vb_line_dirty = 1'b0;
        #1;
        check("t5_no_grant0", 65'(vb_icc_grant), 65'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            check("t5_no_grant", 65'(vb_icc_grant), 65'h0);
        end
        check("t5_empty_held", 65'(vb_icc_empty), 65'h1);
        icc_vb_clr_vld = 1'b0;
        #1;
        check("t5_grant_release", 65'(vb_icc_grant), 65'h1);
        cycle();
        icc_vb_create_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            icc_vb_data_create = 1'b1;
            icc_vb_data_cnt = 2'(b);
            icc_vb_data = 64'h3300 + 64'(b);
            cycle();
        end
        icc_vb_data_create = 1'b0;
        wait_idle("t5");

        // Reset in the middle of a burst (beat 1 held by the BIU)
        stall_beat = 1; stall_len = 1000;
        create_line(27'h0000444, 1'b1, 64'h4000, g, grc, glr);
        n = 0;
        @(negedge clk);
        while (!(vb_biu_data_vld && vb_biu_data == 64'h4001) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_at_beat1", 65'(vb_biu_data), 65'h4001);
        cpurst = 1'b1;
        @(posedge clk);
        #3;
        cpurst = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        stall_beat = -1; stall_len = 0;
        #1;
        check("t6_req", 65'(vb_biu_req), 65'h0);
        check("t6_vld", 65'(vb_biu_data_vld), 65'h0);
        check("t6_empty", 65'(vb_icc_empty), 65'h1);
        icc_vb_create_en = 1'b1;
        icc_vb_addr = 27'h0000555;
        icc_vb_line_dirty = 1'b0;
        #1;
        check("t6_grant", 65'(vb_icc_grant), 65'h1);
        icc_vb_create_en = 1'b0;
        repeat (2) cycle();
        check("t6_empty_later", 65'(vb_icc_empty), 65'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
